delay_arbiter: RTL and testbench

Round-robin arbiter and in-flight tracker that shares one fixed-latency pipelined unit among several requesters. The unit itself is a plain delay line of LATENCY stages with no return addressing. This block grants at most one requester per cycle and carries the winner's tag down a matching LATENCY-stage tag/valid line. When the operation leaves the unit, the block raises a one-hot response to the original requester. It sits between the pipeline stages that issue multi-cycle operations and the shared unit.

---
 rtl/delay_arbiter.sv | 137 +++++++++++++
 tb/tb_delay_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined unit, with a matching tag/valid line routing completions.
// Optional flush support is compiled in when DELAY_ARBITER_FLUSH_EN is defined.
module delay_arbiter #(
    parameter int REQS    = 2,
    parameter int LATENCY = 3,
    localparam int IW     = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1)
) (
    input  logic            clock_i,
    input  logic            reset_ni,
    input  logic [REQS-1:0] req_i,
    input  logic            stall_i,
`ifdef DELAY_ARBITER_FLUSH_EN
    input  logic            flush_i,
`endif
    output logic [REQS-1:0] grant_o,
    output logic            issue_o,
    output logic [REQS-1:0] resp_o,
    output logic [IW-1:0]   inflight_o,
    output logic            busy_o
);

    localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     winner;
    logic              anyReq;
    logic              flushW;
    logic              blockGrant;
    logic [2*REQS-1:0] reqDouble;
    logic [REQS-1:0]   reqRot;

`ifdef DELAY_ARBITER_FLUSH_EN
    assign flushW = flush_i;
`else
    assign flushW = 1'b0;
`endif

    // Rotate requests so bit 0 is the current priority holder, then take the first set bit.
    always_comb begin
        int s;
        reqDouble = {req_i, req_i};
        reqRot    = REQS'(reqDouble >> ptr_q);
        winner    = '0;
        anyReq    = 1'b0;
        s         = 0;
        for (int i = 0; i < REQS; i++) begin
            if (!anyReq && reqRot[i]) begin
                anyReq = 1'b1;
                s      = int'(ptr_q) + i;
                if (s >= REQS) s = s - REQS;
                winner = PW'(s);
            end
        end
    end

    assign blockGrant = !reset_ni || stall_i || flushW;
    assign issue_o    = anyReq && !blockGrant;
    assign grant_o    = issue_o ? (REQS'(1) << winner) : '0;

    always_comb begin
        int n;
        ptr_d = ptr_q;
        n     = 0;
        if (issue_o) begin
            n = int'(winner) + 1;
            if (n >= REQS) n = 0;
            ptr_d = PW'(n);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) ptr_q <= '0;
        else           ptr_q <= ptr_d;
    end

    generate
        if (LATENCY > 0) begin : g_pipe
            logic [LATENCY-1:0] v_q, v_d;
            logic [PW-1:0]      t_q [LATENCY];
            logic [PW-1:0]      t_d [LATENCY];
            logic [IW-1:0]      inflight_q, inflight_d;
            logic [REQS-1:0]    respVec;

            // Flush wins over stall; otherwise the whole line shifts only on unstalled cycles.
            always_comb begin
                int cnt;
                v_d = v_q;
                t_d = t_q;
                cnt = 0;
                if (flushW) begin
                    v_d = '0;
                end else if (!stall_i) begin
                    v_d[0] = issue_o;
                    t_d[0] = winner;
                    for (int k = 1; k < LATENCY; k++) begin
                        v_d[k] = v_q[k-1];
                        t_d[k] = t_q[k-1];
                    end
                end
                for (int k = 0; k < LATENCY; k++) begin
                    cnt = cnt + (v_d[k] ? 1 : 0);
                end
                inflight_d = IW'(cnt);
            end

            always_ff @(posedge clock_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    v_q        <= '0;
                    inflight_q <= '0;
                end else begin
                    v_q        <= v_d;
                    inflight_q <= inflight_d;
                end
            end

            always_ff @(posedge clock_i) begin
                t_q <= t_d;
            end

            always_comb begin
                respVec = '0;
                for (int i = 0; i < REQS; i++) begin
                    respVec[i] = v_q[LATENCY-1] && (t_q[LATENCY-1] == PW'(i)) && !stall_i && !flushW;
                end
            end

            assign resp_o     = respVec;
            assign inflight_o = inflight_q;
        end else begin : g_pass
            assign resp_o     = grant_o;
            assign inflight_o = '0;
        end
    endgenerate

    assign busy_o = |inflight_o;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter: a REQS=4/LATENCY=3 instance and a REQS=2/LATENCY=0 instance.
// Flush steps are included only when DELAY_ARBITER_FLUSH_EN is defined.
module tb_delay_arbiter;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] reqA;
    logic       stallA;
    logic       flushA;
    logic [3:0] grantA, respA;
    logic       issueA, busyA;
    logic [1:0] inflightA;

    logic [1:0] reqB;
    logic [1:0] grantB, respB;
    logic       issueB, busyB;
    logic       inflightB;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    delay_arbiter #(.REQS(4), .LATENCY(3)) dutA (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .req_i      (reqA),
        .stall_i    (stallA),
`ifdef DELAY_ARBITER_FLUSH_EN
        .flush_i    (flushA),
`endif
        .grant_o    (grantA),
        .issue_o    (issueA),
        .resp_o     (respA),
        .inflight_o (inflightA),
        .busy_o     (busyA)
    );

    delay_arbiter #(.REQS(2), .LATENCY(0)) dutB (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .req_i      (reqB),
        .stall_i    (1'b0),
`ifdef DELAY_ARBITER_FLUSH_EN
        .flush_i    (1'b0),
`endif
        .grant_o    (grantB),
        .issue_o    (issueB),
        .resp_o     (respB),
        .inflight_o (inflightB),
        .busy_o     (busyB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic s, input logic f);
        reqA   = r;
        stallA = s;
        flushA = f;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkA(input string tag, input logic [3:0] eg, input logic [3:0] er, input logic [1:0] ei);
        checkOutput({tag, ".grant"},    32'(grantA),    32'(eg));
        checkOutput({tag, ".issue"},    32'(issueA),    32'(|eg));
        checkOutput({tag, ".resp"},     32'(respA),     32'(er));
        checkOutput({tag, ".inflight"}, 32'(inflightA), 32'(ei));
        checkOutput({tag, ".busy"},     32'(busyA),     32'(ei != 2'd0));
    endtask

    // One full cycle: drive, sample mid-cycle, advance past the edge.
    task automatic cycleA(input string tag, input logic [3:0] r, input logic s, input logic f,
                          input logic [3:0] eg, input logic [3:0] er, input logic [1:0] ei);
        applyStimulus(r, s, f);
        @(negedge clock);
        checkA(tag, eg, er, ei);
        nextCycle();
    endtask

    initial begin
        reset_n = 1'b0;
        reqB    = 2'b00;
        applyStimulus(4'b1111, 1'b0, 1'b0);
        #2;
        checkA("reset", 4'b0000, 4'b0000, 2'd0);
        nextCycle();
        reset_n = 1'b1;

        cycleA("t1c0", 4'b0100, 0, 0, 4'b0100, 4'b0000, 2'd0);
        cycleA("t1c1", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t1c2", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t1c3", 4'b0000, 0, 0, 4'b0000, 4'b0100, 2'd1);
        cycleA("t1c4", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0);

        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;

        for (int c = 0; c < 12; c++) begin
            logic [3:0] eg, er;
            logic [1:0] ei;
            eg = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            er = (c >= 3 && c < 11) ? (4'b0001 << ((c - 3) % 4)) : 4'b0000;
            ei = (c <= 3) ? 2'(c) : ((c <= 8) ? 2'd3 : 2'(11 - c));
            cycleA($sformatf("t2c%0d", c), (c < 8) ? 4'b1111 : 4'b0000, 0, 0, eg, er, ei);
        end

        cycleA("t3c0", 4'b0001, 0, 0, 4'b0001, 4'b0000, 2'd0);
        cycleA("t3c1", 4'b0010, 0, 0, 4'b0010, 4'b0000, 2'd1);
        cycleA("t3c2", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd2);
        cycleA("t3c3", 4'b1111, 1, 0, 4'b0000, 4'b0000, 2'd2);
        cycleA("t3c4", 4'b1111, 1, 0, 4'b0000, 4'b0000, 2'd2);
        cycleA("t3c5", 4'b0000, 0, 0, 4'b0000, 4'b0001, 2'd2);
        cycleA("t3c6", 4'b0000, 0, 0, 4'b0000, 4'b0010, 2'd1);
        cycleA("t3c7", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0);

        cycleA("t4c0", 4'b1111, 0, 0, 4'b0100, 4'b0000, 2'd0);
        cycleA("t4c1", 4'b1111, 0, 0, 4'b1000, 4'b0000, 2'd1);
        cycleA("t4c2", 4'b1111, 0, 0, 4'b0001, 4'b0000, 2'd2);
        applyStimulus(4'b0000, 0, 0);
        @(negedge clock);
        checkOutput("t4c3.inflight", 32'(inflightA), 32'd3);
        checkOutput("t4c3.resp", 32'(respA), 32'(4'b0100));
        #1;
        reset_n = 1'b0;
        applyStimulus(4'b1111, 0, 0);
        #1;
        checkA("t4rst", 4'b0000, 4'b0000, 2'd0);
        nextCycle();
        reset_n = 1'b1;
        cycleA("t4r0", 4'b1111, 0, 0, 4'b0001, 4'b0000, 2'd0);
        cycleA("t4r1", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t4r2", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t4r3", 4'b0000, 0, 0, 4'b0000, 4'b0001, 2'd1);
        cycleA("t4r4", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0);

`ifdef DELAY_ARBITER_FLUSH_EN
        cycleA("t5c0", 4'b1111, 0, 0, 4'b0010, 4'b0000, 2'd0);
        cycleA("t5c1", 4'b1111, 0, 0, 4'b0100, 4'b0000, 2'd1);
        cycleA("t5c2", 4'b1111, 0, 0, 4'b1000, 4'b0000, 2'd2);
        cycleA("t5c3", 4'b1111, 0, 1, 4'b0000, 4'b0000, 2'd3);
        cycleA("t5c4", 4'b0001, 0, 0, 4'b0001, 4'b0000, 2'd0);
        cycleA("t5c5", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t5c6", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd1);
        cycleA("t5c7", 4'b0000, 0, 0, 4'b0000, 4'b0001, 2'd1);
        cycleA("t5c8", 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0);
`endif

        reqB = 2'b11;
        for (int c = 0; c < 4; c++) begin
            logic [1:0] eg;
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clock);
            checkOutput($sformatf("t6c%0d.grant", c),    32'(grantB),    32'(eg));
            checkOutput($sformatf("t6c%0d.resp", c),     32'(respB),     32'(eg));
            checkOutput($sformatf("t6c%0d.issue", c),    32'(issueB),    32'd1);
            checkOutput($sformatf("t6c%0d.inflight", c), 32'(inflightB), 32'd0);
            checkOutput($sformatf("t6c%0d.busy", c),     32'(busyB),     32'd0);
            nextCycle();
        end
        reqB = 2'b00;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
